// File: rtl/viterbi_pkg.sv
// viterbi_pkg
//   Shared definitions for the K=3, rate-1/2 convolutional code with
//   generators 7 (111) and 5 (101) octal. Used by the companion encoder2
//   and by viterbi_k3_decoder so both ends agree on the code.
//
//   Contents:
//     K, NUM_STATES   constraint length and trellis state count
//     G0, G1          generator taps applied to {u, p1, p0}
//     state_t         encoder state {p1, p0}; p1 = previous info bit
//     exp_symbol()    channel symbol {c1, c0} emitted from state p on input u
package viterbi_pkg;

   localparam int         K          = 3;
   localparam int         NUM_STATES = 4;
   localparam logic [2:0] G0         = 3'b111;
   localparam logic [2:0] G1         = 3'b101;

   typedef logic [1:0] state_t;

   // The shift register is {u, p1, p0}; each output bit is the parity of the
   // taps selected by its generator.
   function automatic logic [1:0] exp_symbol(state_t p, logic u);
      logic [2:0] sr;
      sr = {u, p};
      return {^(sr & G0), ^(sr & G1)};
   endfunction

endpackage

// File: rtl/viterbi_acs.sv
// viterbi_acs
//   Compare-select stage for one trellis state. The two candidate metrics
//   arrive already added (predecessor metric + branch metric).
//
//   Ports:
//     cand0_in      candidate through the predecessor with p0 = 0
//     cand1_in      candidate through the predecessor with p0 = 1
//     metric_out    surviving (smaller) candidate
//     decision_out  1 when the p0 = 1 predecessor survives
module viterbi_acs
   import viterbi_pkg::*;
#(
   parameter int MW = 6
) (
   input  logic [MW-1:0] cand0_in,
   input  logic [MW-1:0] cand1_in,
   output logic [MW-1:0] metric_out,
   output logic          decision_out
);

   // Strict less-than so a tie keeps the p0 = 0 predecessor.
   always_comb begin
      decision_out = (cand1_in < cand0_in);
      metric_out   = decision_out ? cand1_in : cand0_in;
   end

endmodule

// File: rtl/viterbi_k3_decoder.sv
// viterbi_k3_decoder
//   Hard-decision Viterbi decoder for the K=3 (7,5) rate-1/2 code. Runs a
//   4-state add-compare-select with Hamming branch metrics, keeps survivors
//   by register exchange and emits one decoded bit per symbol once the
//   survivors are TB_DEPTH symbols deep.
//
//   Parameters:
//     TB_DEPTH  survivor length / decision depth in symbols (4..64)
//     MW        path-metric width in bits
//
//   Ports:
//     clk          rising-edge clock
//     rst          asynchronous, active-low reset
//     enable       d_in holds a valid symbol this cycle
//     d_in         received symbol: [1] = G0 (111) bit, [0] = G1 (101) bit
//     d_out        registered decoded bit (holds while enable is low)
//     d_out_valid  d_out was updated with a real decision this cycle
//     err_cnt      (only with VITERBI_ERR_CNT_EN) saturating sum of the
//                  best-metric increments, an estimate of corrected bit errors
//
//   Optional feature macro: VITERBI_ERR_CNT_EN
module viterbi_k3_decoder
   import viterbi_pkg::*;
#(
   parameter int TB_DEPTH = 16,
   parameter int MW       = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [1:0]  d_in,
`ifdef VITERBI_ERR_CNT_EN
   output logic [15:0] err_cnt,
`endif
   output logic        d_out,
   output logic        d_out_valid
);

   localparam int            CW       = $clog2(TB_DEPTH);
   localparam logic [MW-1:0] PM_MAX   = '1;
   localparam logic [MW-1:0] PM_INIT  = {1'b0, {(MW-1){1'b1}}};
   localparam logic [CW-1:0] FILL_MAX = CW'(TB_DEPTH - 1);

   logic [MW-1:0]       pm_q      [NUM_STATES];
   logic [MW-1:0]       pm_d      [NUM_STATES];
   logic [MW-1:0]       pm_next   [NUM_STATES];
   logic [TB_DEPTH-1:0] surv_q    [NUM_STATES];
   logic [TB_DEPTH-1:0] surv_d    [NUM_STATES];
   logic [TB_DEPTH-1:0] surv_next [NUM_STATES];
   logic [MW-1:0]       acs_metric[NUM_STATES];
   logic                acs_dec   [NUM_STATES];
   logic [CW-1:0]       fill_q, fill_d;
   logic                d_out_q, d_out_d;
   logic                d_out_valid_q, d_out_valid_d;
   logic [MW-1:0]       min_raw;
   state_t              best;

   function automatic logic [1:0] branch_metric(state_t p, logic u, logic [1:0] sym);
      logic [1:0] diff;
      diff = exp_symbol(p, u) ^ sym;
      return {1'b0, diff[1]} + {1'b0, diff[0]};
   endfunction

   function automatic logic [MW-1:0] sat_add(logic [MW-1:0] pm, logic [1:0] bm);
      logic [MW:0] sum;
      sum = {1'b0, pm} + {{(MW-1){1'b0}}, bm};
      return sum[MW] ? PM_MAX : sum[MW-1:0];
   endfunction

   // New state {a, b} is reached from {b, 0} and {b, 1} by shifting in a.
   for (genvar ns = 0; ns < NUM_STATES; ns++) begin : g_acs
      localparam state_t PRED0 = state_t'(2 * (ns % 2));
      localparam state_t PRED1 = state_t'(2 * (ns % 2) + 1);
      localparam logic   U     = ((ns / 2) == 1);

      logic [MW-1:0] cand0, cand1;

      assign cand0 = sat_add(pm_q[PRED0], branch_metric(PRED0, U, d_in));
      assign cand1 = sat_add(pm_q[PRED1], branch_metric(PRED1, U, d_in));

      viterbi_acs #(.MW(MW)) u_acs (
         .cand0_in    (cand0),
         .cand1_in    (cand1),
         .metric_out  (acs_metric[ns]),
         .decision_out(acs_dec[ns])
      );

      assign pm_next[ns]   = acs_metric[ns] - min_raw;
      assign surv_next[ns] = {(acs_dec[ns] ? surv_q[PRED1][TB_DEPTH-2:0]
                                           : surv_q[PRED0][TB_DEPTH-2:0]), U};
   end

   // Lowest new metric wins; scanning upward with strict less-than gives
   // ties to the lowest state index.
   always_comb begin
      min_raw = acs_metric[0];
      best    = '0;
      for (int s = 1; s < NUM_STATES; s++) begin
         if (acs_metric[s] < min_raw) begin
            min_raw = acs_metric[s];
            best    = state_t'(s);
         end
      end
   end

   always_comb begin
      pm_d          = pm_q;
      surv_d        = surv_q;
      fill_d        = fill_q;
      d_out_d       = d_out_q;
      d_out_valid_d = 1'b0;
      if (enable) begin
         pm_d          = pm_next;
         surv_d        = surv_next;
         d_out_d       = surv_next[best][TB_DEPTH-1];
         d_out_valid_d = (fill_q == FILL_MAX);
         if (fill_q != FILL_MAX) begin
            fill_d = fill_q + 1'b1;
         end
      end
   end

   // State 0 starts at zero and the others at half range, so decoding
   // assumes the encoder began in state 00.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < NUM_STATES; s++) begin
            pm_q[s]   <= (s == 0) ? '0 : PM_INIT;
            surv_q[s] <= '0;
         end
         fill_q        <= '0;
         d_out_q       <= 1'b0;
         d_out_valid_q <= 1'b0;
      end else begin
         pm_q          <= pm_d;
         surv_q        <= surv_d;
         fill_q        <= fill_d;
         d_out_q       <= d_out_d;
         d_out_valid_q <= d_out_valid_d;
      end
   end

   assign d_out       = d_out_q;
   assign d_out_valid = d_out_valid_q;

`ifdef VITERBI_ERR_CNT_EN
   logic [15:0] err_cnt_q, err_cnt_d;
   logic [16:0] err_sum;

   // Stored metrics are normalised so the previous best is 0; the raw
   // minimum is therefore exactly the increase of the best path metric.
   always_comb begin
      err_sum   = {1'b0, err_cnt_q} + 17'(min_raw);
      err_cnt_d = err_cnt_q;
      if (enable) begin
         err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_viterbi_k3_decoder.sv
// tb_viterbi_k3_decoder
//   Self-checking bench for viterbi_k3_decoder (TB_DEPTH=16, MW=6).
//   A fixed vector table covers the known 1,0,1,1 encoding; random streams
//   are encoded by a generator-polynomial model and the DUT is compared each
//   symbol against a traceback Viterbi reference (full decision history,
//   trace back TB_DEPTH-1 steps from the best state) and, where the channel
//   is clean enough, against the transmitted bits themselves.
//   Optional feature macro: VITERBI_ERR_CNT_EN (adds err_cnt checks).
module tb_viterbi_k3_decoder;

   localparam int TB_DEPTH = 16;
   localparam int MW       = 6;
   localparam int PM_SAT   = 2**MW - 1;
   localparam int PM_INIT  = 2**(MW-1) - 1;

   logic       clk    = 1'b0;
   logic       rst    = 1'b1;
   logic       enable = 1'b0;
   logic [1:0] d_in   = 2'b00;
   logic       d_out;
   logic       d_out_valid;
`ifdef VITERBI_ERR_CNT_EN
   logic [15:0] err_cnt;
`endif

   always #5 clk = ~clk;

   viterbi_k3_decoder #(.TB_DEPTH(TB_DEPTH), .MW(MW)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .d_in       (d_in),
`ifdef VITERBI_ERR_CNT_EN
      .err_cnt    (err_cnt),
`endif
      .d_out      (d_out),
      .d_out_valid(d_out_valid)
   );

   int num_compared   = 0;
   int num_mismatched = 0;

   // Reference decoder state
   int         m_pm[4];
   logic [3:0] m_dec[$];
   int         m_count;
   logic       m_dout;
   logic       m_valid;
   int         m_err;

   // Transmit side: two previous info bits (bit1 = newest) and the bits sent
   int   enc_hist;
   logic info_q[$];

   typedef struct {
      logic [1:0] sym;
      logic       exp_dout;
      logic       exp_valid;
   } vec_t;

   vec_t vecs[20];

   function automatic logic [1:0] enc_symbol(input int hist, input logic u);
      int sr;
      sr = (int'(u) << 2) | hist;
      return {1'($countones(sr & 7) % 2), 1'($countones(sr & 5) % 2)};
   endfunction

   function automatic void modelReset();
      m_pm[0] = 0;
      for (int s = 1; s < 4; s++) m_pm[s] = PM_INIT;
      m_dec.delete();
      m_count  = 0;
      m_dout   = 1'b0;
      m_valid  = 1'b0;
      m_err    = 0;
      enc_hist = 0;
      info_q.delete();
   endfunction

   function automatic void modelStep(input logic [1:0] sym);
      int         raw[4];
      logic [3:0] dec;
      int         c0, c1, p, mn, best, s, idx;
      logic [3:0] dv;
      for (int ns = 0; ns < 4; ns++) begin
         p  = 2 * (ns % 2);
         c0 = m_pm[p] + $countones(enc_symbol(p, 1'(ns / 2)) ^ sym);
         c1 = m_pm[p + 1] + $countones(enc_symbol(p + 1, 1'(ns / 2)) ^ sym);
         if (c0 > PM_SAT) c0 = PM_SAT;
         if (c1 > PM_SAT) c1 = PM_SAT;
         dec[ns] = (c1 < c0);
         raw[ns] = (c1 < c0) ? c1 : c0;
      end
      mn   = raw[0];
      best = 0;
      for (int ns = 1; ns < 4; ns++) begin
         if (raw[ns] < mn) begin
            mn   = raw[ns];
            best = ns;
         end
      end
      m_err = (m_err + mn > 65535) ? 65535 : m_err + mn;
      for (int ns = 0; ns < 4; ns++) m_pm[ns] = raw[ns] - mn;
      m_dec.push_back(dec);
      s   = best;
      idx = m_dec.size() - 1;
      for (int k = 0; k < TB_DEPTH - 1; k++) begin
         if (idx < 0) break;
         dv  = m_dec[idx];
         s   = 2 * (s % 2) + int'(dv[s]);
         idx = idx - 1;
      end
      m_valid = (m_count >= TB_DEPTH - 1);
      m_dout  = m_valid ? 1'(s / 2) : 1'b0;
      m_count = m_count + 1;
   endfunction

   task automatic checkBit(input string name, input int actual, input int expected);
      num_compared = num_compared + 1;
      if (actual !== expected) begin
         num_mismatched = num_mismatched + 1;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkBit({tag, "_dout"}, int'(d_out), int'(m_dout));
      checkBit({tag, "_valid"}, int'(d_out_valid), int'(m_valid));
`ifdef VITERBI_ERR_CNT_EN
      checkBit({tag, "_err_cnt"}, int'(err_cnt), m_err);
`endif
   endtask

   // Drive on the falling edge, sample 1 time unit after the rising edge.
   task automatic applyStimulus(input logic [1:0] sym, input logic en);
      @(negedge clk);
      d_in   = sym;
      enable = en;
      if (en) modelStep(sym);
      else    m_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst    = 1'b0;
      enable = 1'b0;
      d_in   = 2'b00;
      repeat (2) @(negedge clk);
      modelReset();
      checkBit("reset_dout", int'(d_out), 0);
      checkBit("reset_valid", int'(d_out_valid), 0);
`ifdef VITERBI_ERR_CNT_EN
      checkBit("reset_err_cnt", int'(err_cnt), 0);
`endif
      rst = 1'b1;
   endtask

   task automatic sendBit(input logic u, input logic [1:0] flip, input bit check_truth);
      logic [1:0] sym;
      int         n;
      sym      = enc_symbol(enc_hist, u) ^ flip;
      enc_hist = (int'(u) << 1) | (enc_hist >> 1);
      info_q.push_back(u);
      n = info_q.size() - 1;
      applyStimulus(sym, 1'b1);
      checkOutput("model");
      if (check_truth && n >= TB_DEPTH - 1) begin
         checkBit("truth_dout", int'(d_out), int'(info_q[n - (TB_DEPTH - 1)]));
         checkBit("truth_valid", int'(d_out_valid), 1);
      end
   endtask

   task automatic idleCycle();
      logic held;
      held = d_out;
      applyStimulus(2'($urandom), 1'b0);
      checkBit("gap_dout_frozen", int'(d_out), int'(held));
      checkBit("gap_valid_low", int'(d_out_valid), 0);
      checkOutput("model_gap");
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int bstart;
      int bit_diffs;
      logic [1:0] flip;

      // Info 1,0,1,1 then zeros encodes to 11,10,00,01,01,11,00...
      for (int i = 0; i < 20; i++) begin
         vecs[i].sym       = 2'b00;
         vecs[i].exp_dout  = 1'b0;
         vecs[i].exp_valid = (i >= TB_DEPTH - 1);
      end
      vecs[0].sym = 2'b11;
      vecs[1].sym = 2'b10;
      vecs[2].sym = 2'b00;
      vecs[3].sym = 2'b01;
      vecs[4].sym = 2'b01;
      vecs[5].sym = 2'b11;
      vecs[15].exp_dout = 1'b1;
      vecs[16].exp_dout = 1'b0;
      vecs[17].exp_dout = 1'b1;
      vecs[18].exp_dout = 1'b1;

      $display("[TB] reset and known-sequence table");
      doReset();
      for (int i = 0; i < 20; i++) begin
         applyStimulus(vecs[i].sym, 1'b1);
         checkBit($sformatf("table%0d_dout", i), int'(d_out), int'(vecs[i].exp_dout));
         checkBit($sformatf("table%0d_valid", i), int'(d_out_valid), int'(vecs[i].exp_valid));
      end

      $display("[TB] error-free random stream");
      doReset();
      for (int i = 0; i < 256; i++) sendBit(1'($urandom), 2'b00, 1'b1);

      $display("[TB] single error on d_in[1] of symbol 40");
      doReset();
      for (int i = 0; i < 256; i++) sendBit(1'($urandom), (i == 40) ? 2'b10 : 2'b00, 1'b1);
`ifdef VITERBI_ERR_CNT_EN
      checkBit("single_error_err_cnt", int'(err_cnt), 1);
`endif

      // Bursts only in even 32-symbol windows, starting at offset 0..27, so
      // consecutive bursts are always more than 32 clean symbols apart.
      // A 4-bit burst on c0 lies at distance 2 from the weight-6 codeword
      // 11 01 01 11, so maximum-likelihood decoding may legitimately differ
      // from the sent bits here; the reference decoder is the judge.
      $display("[TB] 4-symbol bursts on d_in[0]");
      doReset();
      bstart    = -1;
      bit_diffs = 0;
      for (int i = 0; i < 1024; i++) begin
         if (i % 32 == 0) bstart = ((i / 32) % 2 == 0) ? i + int'($urandom_range(0, 27)) : -1;
         flip = (bstart >= 0 && i >= bstart && i < bstart + 4) ? 2'b01 : 2'b00;
         sendBit(1'($urandom), flip, 1'b0);
         if (i >= TB_DEPTH - 1 && d_out !== info_q[i - (TB_DEPTH - 1)]) bit_diffs++;
      end
      $display("[TB] burst stream: %0d decoded bits differ from the sent bits", bit_diffs);

      $display("[TB] idle gap every third cycle");
      doReset();
      for (int i = 0; i < 96; i++) begin
         sendBit(1'($urandom), 2'b00, 1'b1);
         if (i % 2 == 1) idleCycle();
      end

      $display("[TB] asynchronous reset at symbol 100");
      doReset();
      for (int i = 0; i < 100; i++) sendBit(1'($urandom), 2'b00, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      checkBit("async_reset_dout", int'(d_out), 0);
      checkBit("async_reset_valid", int'(d_out_valid), 0);
      doReset();
      for (int i = 0; i < 64; i++) sendBit(1'($urandom), 2'b00, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
      $finish;
   end

endmodule
